control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multi-cycle fetch/execute control unit for the 4-bit microprocessor.
- Sits directly upstream of the datapath registers: produces each register's clock-enable (CE), the source-select for the shared register input bus, the ALU operation, the immediate field and the program-ROM address.
- Each instruction takes two cycles: FETCH then EXEC.
- ALU, register file and ROM are external to this block.

Parameters:
- WIDTH, 4, data/immediate width; equals the register width.
- PC_WIDTH, 4, program counter width; ROM depth is 2^PC_WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  run enable; low freezes the sequencer.
- INSTR  input  8  ROM data at address PC; [7:4] opcode, [3:0] immediate/target.
- ZERO  input  1  datapath flag, high when register A == 0.
- PC  output  PC_WIDTH  ROM address (registered).
- REG_CE  output  3  load enables: [0]=A, [1]=B, [2]=OUT.
- SRC_SEL  output  2  register input bus select: 0=IMM, 1=ALU result, 2=A.
- ALU_OP  output  1  0=A+B, 1=A−B.
- IMM  output  WIDTH  IR[3:0], zero-extended or truncated to WIDTH.
- HALTED  output  1  high while in the HALT state.

Behaviour:
- Reset: synchronous, active-high, dominates EN.
  - After the reset edge: state=FETCH, PC=0, IR=8'h00, HALTED=0.
  - REG_CE=0 in every cycle where RST=1, including the cycle in which RST is asserted mid-EXEC. No register may load during reset.
- States: FETCH, EXEC, HALT. Encoding is free.
- FETCH, when EN=1:
  - IR <= INSTR.
  - Next state EXEC.
  - REG_CE=0.
- EXEC, when EN=1: outputs are decoded combinationally from IR and ZERO. The targeted CE is high for exactly this cycle, so the register captures on the EXEC→FETCH edge. Unless stated otherwise, PC <= PC+1 (wraps modulo 2^PC_WIDTH) and next state is FETCH.
  - 0x0 NOP: no CE.
  - 0x1 LDI: SRC_SEL=0, REG_CE[0]=1.
  - 0x2 MOV B,A: SRC_SEL=2, REG_CE[1]=1.
  - 0x3 ADD: SRC_SEL=1, ALU_OP=0, REG_CE[0]=1. Result is truncated to WIDTH; no carry flag.
  - 0x4 SUB: SRC_SEL=1, ALU_OP=1, REG_CE[0]=1. Result wraps modulo 2^WIDTH.
  - 0x5 JMP: PC <= IMM resized to PC_WIDTH. No CE.
  - 0x6 JZ: if ZERO=1, PC <= IMM; else PC+1. ZERO is sampled in the EXEC cycle.
  - 0x7 OUT: SRC_SEL=2, REG_CE[2]=1.
  - 0xF HLT: PC unchanged, next state HALT. No CE.
  - 0x8–0xE: executed as NOP.
- HALT:
  - REG_CE=0; PC and IR frozen; HALTED=1.
  - Exit only through RST.
- EN=0 in any state:
  - State, PC and IR hold.
  - REG_CE forced to 0.
  - SRC_SEL, ALU_OP and IMM may still reflect IR.
  - Deasserting EN during EXEC cancels the CE for that cycle. The instruction re-executes when EN returns (state is still EXEC).
- Outside EXEC: SRC_SEL=0 and ALU_OP=0 (defined defaults, no X).
- At most one REG_CE bit is high in any cycle.
- PC wrap: JZ/NOP at PC=2^PC_WIDTH−1 advances to 0.
- Throughput: one instruction per 2 enabled cycles; a jump costs no extra cycle.

Test Plan:
- Reset then program LDI 5; MOV; LDI 3; ADD; OUT; HLT → REG_CE pulses in the sequence 001,010,001,001,100 on cycles 2,4,6,8,10. Datapath OUT=8. HALTED rises after cycle 12 with PC=5.
- A=0, then JZ 0xA at PC=3 → PC=0xA at the next FETCH. Repeat with A=1 → PC=4.
- Program of 16 NOPs → PC reaches 0xF, then wraps to 0x0 after 32 cycles. REG_CE stays 0 throughout.
- EN low for 3 cycles while in EXEC of LDI 7 → REG_CE=0 and PC held during the stall. The LDI completes (REG_CE[0]=1, A=7) on the first enabled cycle.
- RST asserted during EXEC of ADD → REG_CE=0 in that cycle. Next cycle: state=FETCH, PC=0, HALTED=0.
- Opcode 0xB executed; then HLT followed by 10 cycles with EN=1 → 0xB behaves as NOP (PC+1, no CE). After HLT, PC is frozen, HALTED=1 and there are no CE pulses until RST.

Source files
------------

// File: rtl/control_sequencer.sv
// Two-phase (FETCH/EXEC) control unit for the 4-bit microprocessor.
// Drives datapath load enables, bus select, ALU op, immediate and ROM address.
module control_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PC_WIDTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic [7:0]          INSTR,
  input  logic                ZERO,
  output logic [PC_WIDTH-1:0] PC,
  output logic [2:0]          REG_CE,
  output logic [1:0]          SRC_SEL,
  output logic                ALU_OP,
  output logic [WIDTH-1:0]    IMM,
  output logic                HALTED
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_OUT = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] SEL_IMM = 2'd0;
  localparam logic [1:0] SEL_ALU = 2'd1;
  localparam logic [1:0] SEL_A   = 2'd2;

  localparam logic [2:0] CE_A   = 3'b001;
  localparam logic [2:0] CE_B   = 3'b010;
  localparam logic [2:0] CE_OUT = 3'b100;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              state;
  logic [7:0]          ir;
  logic [3:0]          opcode;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [2:0]          ce_dec;
  logic [1:0]          sel_dec;
  logic                op_dec;

  assign opcode = ir[7:4];
  assign pc_inc = PC + PC_ONE;

  // The 4-bit field is zero-extended or truncated independently for data and address width.
  if (WIDTH > 4) begin : g_imm_ext
    assign IMM = {{(WIDTH-4){1'b0}}, ir[3:0]};
  end else if (WIDTH == 4) begin : g_imm_eq
    assign IMM = ir[3:0];
  end else begin : g_imm_trunc
    assign IMM = ir[WIDTH-1:0];
  end

  if (PC_WIDTH > 4) begin : g_tgt_ext
    assign jump_target = {{(PC_WIDTH-4){1'b0}}, ir[3:0]};
  end else if (PC_WIDTH == 4) begin : g_tgt_eq
    assign jump_target = ir[3:0];
  end else begin : g_tgt_trunc
    assign jump_target = ir[PC_WIDTH-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_FETCH;
      PC     <= '0;
      ir     <= 8'h00;
      HALTED <= 1'b0;
    end else if (EN) begin
      case (state)
        S_FETCH: begin
          ir    <= INSTR;
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (opcode)
            OP_JMP: begin
              PC    <= jump_target;
              state <= S_FETCH;
            end
            OP_JZ: begin
              PC    <= ZERO ? jump_target : pc_inc;
              state <= S_FETCH;
            end
            OP_HLT: begin
              state  <= S_HALT;
              HALTED <= 1'b1;
            end
            default: begin
              PC    <= pc_inc;
              state <= S_FETCH;
            end
          endcase
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Decode is combinational so the load enable lands on the EXEC->FETCH edge.
  always_comb begin
    ce_dec  = 3'b000;
    sel_dec = SEL_IMM;
    op_dec  = 1'b0;
    if (state == S_EXEC) begin
      case (opcode)
        OP_LDI: begin
          sel_dec = SEL_IMM;
          ce_dec  = CE_A;
        end
        OP_MOV: begin
          sel_dec = SEL_A;
          ce_dec  = CE_B;
        end
        OP_ADD: begin
          sel_dec = SEL_ALU;
          op_dec  = 1'b0;
          ce_dec  = CE_A;
        end
        OP_SUB: begin
          sel_dec = SEL_ALU;
          op_dec  = 1'b1;
          ce_dec  = CE_A;
        end
        OP_OUT: begin
          sel_dec = SEL_A;
          ce_dec  = CE_OUT;
        end
        OP_NOP, OP_JMP, OP_JZ, OP_HLT: ce_dec = 3'b000;
        default: ce_dec = 3'b000;
      endcase
    end
  end

  // Stalls and reset must suppress the load in the very cycle they are asserted.
  assign REG_CE  = (EN && !RST) ? ce_dec : 3'b000;
  assign SRC_SEL = sel_dec;
  assign ALU_OP  = op_dec;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a small ROM/datapath and an ISA-level model.
module tb_control_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN  = 1'b1;
  logic [7:0] INSTR;
  logic       ZERO;
  logic [3:0] PC;
  logic [2:0] REG_CE;
  logic [1:0] SRC_SEL;
  logic       ALU_OP;
  logic [3:0] IMM;
  logic       HALTED;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  bit any_ce = 1'b0;

  logic [7:0] rom [16];
  logic [3:0] dp_a = 4'd0, dp_b = 4'd0, dp_out = 4'd0;
  logic [3:0] bus;

  // ISA-level model: phase 0=fetch, 1=execute, 2=halted
  int         m_ph = 0;
  logic [3:0] m_pc = 4'd0;
  logic [7:0] m_ir = 8'd0;

  control_sequencer #(.WIDTH(4), .PC_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .INSTR(INSTR), .ZERO(ZERO),
    .PC(PC), .REG_CE(REG_CE), .SRC_SEL(SRC_SEL), .ALU_OP(ALU_OP),
    .IMM(IMM), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  assign INSTR = rom[PC];
  assign ZERO  = (dp_a == 4'd0);

  always_comb begin
    bus = 4'd0;
    case (SRC_SEL)
      2'd0: bus = IMM;
      2'd1: bus = ALU_OP ? (dp_a - dp_b) : (dp_a + dp_b);
      2'd2: bus = dp_a;
      default: bus = 4'd0;
    endcase
  end

  always @(posedge CLK) begin
    if (REG_CE[0]) dp_a   <= bus;
    if (REG_CE[1]) dp_b   <= bus;
    if (REG_CE[2]) dp_out <= bus;
  end

  always @(posedge CLK) begin
    if (RST) begin
      m_ph <= 0;
      m_pc <= 4'd0;
      m_ir <= 8'd0;
    end else if (EN) begin
      if (m_ph == 0) begin
        m_ir <= INSTR;
        m_ph <= 1;
      end else if (m_ph == 1) begin
        case (m_ir[7:4])
          4'h5:    begin m_pc <= m_ir[3:0]; m_ph <= 0; end
          4'h6:    begin m_pc <= ZERO ? m_ir[3:0] : m_pc + 4'd1; m_ph <= 0; end
          4'hF:    m_ph <= 2;
          default: begin m_pc <= m_pc + 4'd1; m_ph <= 0; end
        endcase
      end
    end
  end

  function automatic logic [2:0] ce_of(input logic [3:0] op);
    case (op)
      4'h1, 4'h3, 4'h4: return 3'b001;
      4'h2:             return 3'b010;
      4'h7:             return 3'b100;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] sel_of(input logic [3:0] op);
    case (op)
      4'h2, 4'h7: return 2'd2;
      4'h3, 4'h4: return 2'd1;
      default:    return 2'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("pc", {4'd0, PC}, {4'd0, m_pc});
      check("reg_ce", {5'd0, REG_CE},
            {5'd0, (m_ph == 1 && EN && !RST) ? ce_of(m_ir[7:4]) : 3'b000});
      check("src_sel", {6'd0, SRC_SEL}, {6'd0, (m_ph == 1) ? sel_of(m_ir[7:4]) : 2'd0});
      check("alu_op", {7'd0, ALU_OP}, {7'd0, (m_ph == 1 && m_ir[7:4] == 4'h4)});
      check("imm", {4'd0, IMM}, {4'd0, m_ir[3:0]});
      check("halted", {7'd0, HALTED}, {7'd0, (m_ph == 2)});
      if (REG_CE != 3'b000) any_ce = 1'b1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    EN  = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ce_lit [12];
    ce_lit = '{0, 1, 0, 2, 0, 1, 0, 1, 0, 4, 0, 0};
    clear_rom();

    // Program: LDI 5; MOV; LDI 3; ADD; OUT; HLT
    rom[0] = 8'h15; rom[1] = 8'h20; rom[2] = 8'h13;
    rom[3] = 8'h30; rom[4] = 8'h70; rom[5] = 8'hF0;
    do_reset();
    check("reset_pc", {4'd0, PC}, 8'h00);
    check("reset_halted", {7'd0, HALTED}, 8'h00);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("prog_ce_c%0d", k + 1), {5'd0, REG_CE}, ce_lit[k][7:0]);
      tick();
    end
    check("prog_halted", {7'd0, HALTED}, 8'h01);
    check("prog_pc", {4'd0, PC}, 8'h05);
    check("prog_out", {4'd0, dp_out}, 8'h08);

    // JZ taken (A=0) and not taken (A=1)
    clear_rom();
    rom[0] = 8'h10; rom[3] = 8'h6A; rom[10] = 8'hF0;
    do_reset();
    tick(8);
    check("jz_taken_pc", {4'd0, PC}, 8'h0A);
    rom[0] = 8'h11;
    do_reset();
    tick(8);
    check("jz_not_taken_pc", {4'd0, PC}, 8'h04);

    // 16 NOPs: wrap after 32 cycles
    clear_rom();
    do_reset();
    any_ce = 1'b0;
    tick(30);
    check("nop_pc_f", {4'd0, PC}, 8'h0F);
    tick(2);
    check("nop_pc_wrap", {4'd0, PC}, 8'h00);
    check("nop_no_ce", {7'd0, any_ce}, 8'h00);

    // Stall during EXEC of LDI 7
    clear_rom();
    rom[0] = 8'h17; rom[1] = 8'hF0;
    do_reset();
    tick();
    EN = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("stall_ce", {5'd0, REG_CE}, 8'h00);
      check("stall_pc", {4'd0, PC}, 8'h00);
      tick();
    end
    EN = 1'b1;
    #1;
    check("stall_resume_ce", {5'd0, REG_CE}, 8'h01);
    tick();
    check("stall_a", {4'd0, dp_a}, 8'h07);
    check("stall_pc_after", {4'd0, PC}, 8'h01);

    // Reset during EXEC of ADD
    clear_rom();
    rom[0] = 8'h12; rom[1] = 8'h20; rom[2] = 8'h30;
    do_reset();
    tick(5);
    RST = 1'b1;
    #1;
    check("rst_exec_ce", {5'd0, REG_CE}, 8'h00);
    tick();
    RST = 1'b0;
    #1;
    check("rst_pc", {4'd0, PC}, 8'h00);
    check("rst_halted", {7'd0, HALTED}, 8'h00);
    check("rst_a_kept", {4'd0, dp_a}, 8'h02);
    check("rst_fetch_ce", {5'd0, REG_CE}, 8'h00);

    // Undefined opcode 0xB then HLT, then 10 enabled cycles
    clear_rom();
    rom[0] = 8'hB5; rom[1] = 8'hF0;
    do_reset();
    any_ce = 1'b0;
    tick(2);
    check("op_b_pc", {4'd0, PC}, 8'h01);
    tick(2);
    tick(10);
    check("hlt_pc", {4'd0, PC}, 8'h01);
    check("hlt_halted", {7'd0, HALTED}, 8'h01);
    check("hlt_no_ce", {7'd0, any_ce}, 8'h00);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
